// File: rtl/op_decoder_if.sv
// Link-side bundle for op_decoder: deserializer word strobe plus the
// keyboard/mouse poll request/acknowledge pairs.
interface op_decoder_if;
   logic [39:0] op_data;
   logic        op_valid;
   logic        kb_query_pending;
   logic        kb_query_ack;
   logic        ms_query_pending;
   logic        ms_query_ack;

   modport master (
      output op_data, op_valid, kb_query_ack, ms_query_ack,
      input  kb_query_pending, ms_query_pending
   );

   modport slave (
      input  op_data, op_valid, kb_query_ack, ms_query_ack,
      output kb_query_pending, ms_query_pending
   );
endinterface

// File: rtl/op_decoder.sv
// Host-to-device operation decoder: captures 40-bit operation words, classifies
// them one cycle later and drives LED state, held poll requests and control pulses.
module op_decoder (
   input  logic         clk,
   input  logic         reset_n,
   op_decoder_if.slave  bus,
   output logic [1:0]   led_state,
   output logic         kb_reset_pulse,
   output logic         power_ack_pulse,
   output logic         unknown_op_pulse,
   output logic         query_overrun,
   output logic [7:0]   unknown_count
);

   localparam logic [7:0] B3_HOST  = 8'hc5;
   localparam logic [7:0] B3_POWER = 8'hc4;
   localparam logic [7:0] B2_KB    = 8'h10;
   localparam logic [7:0] B2_MS    = 8'h01;
   localparam logic [7:0] B2_LED   = 8'h00;
   localparam logic [7:0] B2_RESET = 8'hff;
   localparam logic [7:0] B2_POWER = 8'h00;

   logic [39:0] cap_data_q;
   logic        cap_valid_q;

   logic [1:0]  led_q, led_d;
   logic [7:0]  count_q, count_d;
   logic        overrun_q, overrun_d;
   logic        kb_reset_q, power_ack_q, unknown_q;

   logic        dec_kb_poll, dec_ms_poll, dec_led, dec_kb_reset, dec_power, dec_unknown;
   logic [1:0]  poll_hit, ack_in, pend_q, overrun_hit;

   logic [7:0]  byte3, byte2;
   logic        unused_bits;

   assign byte3       = cap_data_q[39:32];
   assign byte2       = cap_data_q[31:24];
   assign unused_bits = ^{cap_data_q[23:18], cap_data_q[15:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_data_q  <= '0;
         cap_valid_q <= 1'b0;
      end else begin
         cap_valid_q <= bus.op_valid;
         if (bus.op_valid) begin
            cap_data_q <= bus.op_data;
         end
      end
   end

   // First match wins; anything not listed falls through to unknown.
   always_comb begin
      dec_kb_poll  = 1'b0;
      dec_ms_poll  = 1'b0;
      dec_led      = 1'b0;
      dec_kb_reset = 1'b0;
      dec_power    = 1'b0;
      dec_unknown  = 1'b0;
      if (cap_valid_q) begin
         if (byte3 == B3_HOST && byte2 == B2_KB)          dec_kb_poll  = 1'b1;
         else if (byte3 == B3_HOST && byte2 == B2_MS)     dec_ms_poll  = 1'b1;
         else if (byte3 == B3_HOST && byte2 == B2_LED)    dec_led      = 1'b1;
         else if (byte3 == B3_HOST && byte2 == B2_RESET)  dec_kb_reset = 1'b1;
         else if (byte3 == B3_POWER && byte2 == B2_POWER) dec_power    = 1'b1;
         else                                             dec_unknown  = 1'b1;
      end
   end

   assign poll_hit = {dec_ms_poll, dec_kb_poll};
   assign ack_in   = {bus.ms_query_ack, bus.kb_query_ack};

   // Index 0 is the keyboard poll channel, index 1 the mouse.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_query
         logic flag_q, flag_d;

         always_comb begin
            flag_d = flag_q;
            if (ack_in[gi])   flag_d = 1'b0;
            if (poll_hit[gi]) flag_d = 1'b1;
            if (dec_kb_reset) flag_d = 1'b0;
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) flag_q <= 1'b0;
            else          flag_q <= flag_d;
         end

         assign pend_q[gi]      = flag_q;
         assign overrun_hit[gi] = poll_hit[gi] & flag_q & ~ack_in[gi];
      end
   endgenerate

   always_comb begin
      led_d = led_q;
      if (dec_led)      led_d = cap_data_q[17:16];
      if (dec_kb_reset) led_d = 2'b00;

      count_d = count_q;
      if (dec_unknown && count_q != 8'hff) count_d = count_q + 8'd1;

      overrun_d = overrun_q | (|overrun_hit);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_q       <= 2'b00;
         count_q     <= 8'h00;
         overrun_q   <= 1'b0;
         kb_reset_q  <= 1'b0;
         power_ack_q <= 1'b0;
         unknown_q   <= 1'b0;
      end else begin
         led_q       <= led_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
         kb_reset_q  <= dec_kb_reset;
         power_ack_q <= dec_power;
         unknown_q   <= dec_unknown;
      end
   end

   assign bus.kb_query_pending = pend_q[0];
   assign bus.ms_query_pending = pend_q[1];
   assign led_state            = led_q;
   assign kb_reset_pulse       = kb_reset_q;
   assign power_ack_pulse      = power_ack_q;
   assign unknown_op_pulse     = unknown_q;
   assign query_overrun        = overrun_q;
   assign unknown_count        = count_q;

endmodule

// File: tb/tb_op_decoder.sv
// Directed vector bench for op_decoder: a table of isolated operations followed by
// hand-written sequences for poll/ack races, back-to-back words, saturation and reset.
module tb_op_decoder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] led_state;
   logic       kb_reset_pulse, power_ack_pulse, unknown_op_pulse, query_overrun;
   logic [7:0] unknown_count;

   int n_applied = 0;
   int n_miscompare = 0;

   op_decoder_if bus();

   op_decoder dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .bus              (bus.slave),
      .led_state        (led_state),
      .kb_reset_pulse   (kb_reset_pulse),
      .power_ack_pulse  (power_ack_pulse),
      .unknown_op_pulse (unknown_op_pulse),
      .query_overrun    (query_overrun),
      .unknown_count    (unknown_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [39:0] word;
      logic [1:0]  led;
      logic        kb_rst;
      logic        pwr;
      logic        unk;
      logic        kbp;
      logic        msp;
      logic [7:0]  cnt;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miscompare++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Strobe one word; returns one cycle after the strobe cycle (N+1).
   task automatic send(input logic [39:0] w);
      bus.op_data  = w;
      bus.op_valid = 1'b1;
      tick();
      bus.op_valid = 1'b0;
   endtask

   initial begin
      bus.op_data      = '0;
      bus.op_valid     = 1'b0;
      bus.kb_query_ack = 1'b0;
      bus.ms_query_ack = 1'b0;

      //            word            led    rst   pwr   unk   kbp   msp   cnt
      vecs[0]  = '{40'hc500020000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{40'hc500030000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{40'hc50001ffff, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{40'hc400000000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{40'hc510000000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      vecs[5]  = '{40'hc501000000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
      vecs[6]  = '{40'hc5ff000000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[7]  = '{40'h1234567890, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
      vecs[8]  = '{40'hc600000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
      vecs[9]  = '{40'hc502000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
      vecs[10] = '{40'hc401000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
      vecs[11] = '{40'hc5fe030000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
      vecs[12] = '{40'hc4005a1234, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5};
      vecs[13] = '{40'hc50003aaaa, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5};

      do_reset();
      chk("rst_led", 32'(led_state), 32'd0);
      chk("rst_pulses", 32'({kb_reset_pulse, power_ack_pulse, unknown_op_pulse}), 32'd0);
      chk("rst_pending", 32'({bus.kb_query_pending, bus.ms_query_pending}), 32'd0);
      chk("rst_overrun", 32'(query_overrun), 32'd0);
      chk("rst_count", 32'(unknown_count), 32'd0);

      for (int i = 0; i < 14; i++) begin
         send(vecs[i].word);
         tick();
         $display("vec %0d word=%010h led=%b rst=%b pwr=%b unk=%b kbp=%b msp=%b cnt=%0d",
                  i, vecs[i].word, led_state, kb_reset_pulse, power_ack_pulse,
                  unknown_op_pulse, bus.kb_query_pending, bus.ms_query_pending, unknown_count);
         chk($sformatf("v%0d_led", i), 32'(led_state), 32'(vecs[i].led));
         chk($sformatf("v%0d_kb_rst", i), 32'(kb_reset_pulse), 32'(vecs[i].kb_rst));
         chk($sformatf("v%0d_pwr", i), 32'(power_ack_pulse), 32'(vecs[i].pwr));
         chk($sformatf("v%0d_unk", i), 32'(unknown_op_pulse), 32'(vecs[i].unk));
         chk($sformatf("v%0d_kbp", i), 32'(bus.kb_query_pending), 32'(vecs[i].kbp));
         chk($sformatf("v%0d_msp", i), 32'(bus.ms_query_pending), 32'(vecs[i].msp));
         chk($sformatf("v%0d_cnt", i), 32'(unknown_count), 32'(vecs[i].cnt));
         chk($sformatf("v%0d_overrun", i), 32'(query_overrun), 32'd0);
         tick();
         chk($sformatf("v%0d_pulse_end", i),
             32'({kb_reset_pulse, power_ack_pulse, unknown_op_pulse}), 32'd0);
      end

      // Keyboard poll held until acked.
      do_reset();
      send(40'hc510000000);
      tick();
      chk("kbpoll_set", 32'(bus.kb_query_pending), 32'd1);
      repeat (5) tick();
      chk("kbpoll_hold", 32'(bus.kb_query_pending), 32'd1);
      bus.kb_query_ack = 1'b1;
      tick();
      bus.kb_query_ack = 1'b0;
      chk("kbpoll_acked", 32'(bus.kb_query_pending), 32'd0);
      chk("kbpoll_no_overrun", 32'(query_overrun), 32'd0);
      $display("seq kbpoll pending=%b overrun=%b", bus.kb_query_pending, query_overrun);

      // Second mouse poll with no ack: overrun.
      send(40'hc501000000);
      tick();
      chk("mspoll_set", 32'(bus.ms_query_pending), 32'd1);
      tick();
      send(40'hc501000000);
      tick();
      chk("mspoll_still", 32'(bus.ms_query_pending), 32'd1);
      chk("mspoll_overrun", 32'(query_overrun), 32'd1);
      $display("seq msoverrun pending=%b overrun=%b", bus.ms_query_pending, query_overrun);

      // Second mouse poll decoded in the same cycle as its ack: set wins, no overrun.
      do_reset();
      send(40'hc501000000);
      tick();
      chk("msrace_set", 32'(bus.ms_query_pending), 32'd1);
      bus.op_data  = 40'hc501000000;
      bus.op_valid = 1'b1;
      tick();
      bus.op_valid     = 1'b0;
      bus.ms_query_ack = 1'b1;
      tick();
      bus.ms_query_ack = 1'b0;
      chk("msrace_pending", 32'(bus.ms_query_pending), 32'd1);
      chk("msrace_overrun", 32'(query_overrun), 32'd0);
      tick();
      chk("msrace_pending_later", 32'(bus.ms_query_pending), 32'd1);
      $display("seq msrace pending=%b overrun=%b", bus.ms_query_pending, query_overrun);

      // Back-to-back power ack, keyboard reset, unknown.
      do_reset();
      send(40'hc500030000);
      send(40'hc510000000);
      tick();
      chk("b2b_pre_led", 32'(led_state), 32'd3);
      chk("b2b_pre_kbp", 32'(bus.kb_query_pending), 32'd1);
      bus.op_data  = 40'hc400000000;
      bus.op_valid = 1'b1;
      tick();
      bus.op_data = 40'hc5ff000000;
      tick();
      bus.op_data = 40'h1234567890;
      chk("b2b_pwr", 32'({kb_reset_pulse, power_ack_pulse, unknown_op_pulse}), 32'b010);
      tick();
      bus.op_valid = 1'b0;
      chk("b2b_kbrst", 32'({kb_reset_pulse, power_ack_pulse, unknown_op_pulse}), 32'b100);
      chk("b2b_led_clr", 32'(led_state), 32'd0);
      chk("b2b_pend_clr", 32'({bus.kb_query_pending, bus.ms_query_pending}), 32'd0);
      tick();
      chk("b2b_unk", 32'({kb_reset_pulse, power_ack_pulse, unknown_op_pulse}), 32'b001);
      chk("b2b_cnt", 32'(unknown_count), 32'd1);
      tick();
      chk("b2b_quiet", 32'({kb_reset_pulse, power_ack_pulse, unknown_op_pulse}), 32'b000);
      $display("seq b2b led=%b cnt=%0d", led_state, unknown_count);

      // Saturation of the unknown counter.
      bus.op_data  = 40'h1234567890;
      bus.op_valid = 1'b1;
      repeat (300) tick();
      bus.op_valid = 1'b0;
      chk("sat_pulse_streaming", 32'(unknown_op_pulse), 32'd1);
      repeat (3) tick();
      chk("sat_cnt", 32'(unknown_count), 32'hff);
      send(40'h0000000000);
      tick();
      chk("sat_hold_pulse", 32'(unknown_op_pulse), 32'd1);
      chk("sat_hold_cnt", 32'(unknown_count), 32'hff);
      $display("seq saturate cnt=%0h", unknown_count);

      // Reset while a word sits in the capture stage: it must be discarded.
      do_reset();
      send(40'hc500030000);
      reset_n = 1'b0;
      #3;
      chk("midrst_led_in_reset", 32'(led_state), 32'd0);
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("midrst_led_%0d", k), 32'(led_state), 32'd0);
         chk($sformatf("midrst_pulses_%0d", k),
             32'({kb_reset_pulse, power_ack_pulse, unknown_op_pulse}), 32'd0);
      end
      send(40'h1234567890);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      chk("midrst_cnt", 32'(unknown_count), 32'd0);
      chk("midrst_unk", 32'(unknown_op_pulse), 32'd0);
      $display("seq midreset led=%b cnt=%0d", led_state, unknown_count);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
      $finish;
   end

endmodule
